pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

PLL bring-up and reset sequencer for the arcade clock tree: runs on the 50 MHz reference clock and drives the PLL's active-high `rst`. It consumes the PLL's asynchronous `locked` and releases the core reset only after lock has been continuously stable. It also detects lock loss and, optionally, retries a PLL that fails to lock within a timeout.

## Interface
- `RST_PULSE_CYCLES`, 10: cycles `pll_rst` is held high per PLL reset pulse (≥2).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK before a timeout (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before core reset release.
- `MAX_RETRIES`, 7: timeouts tolerated before FAIL (1..7).
- `refclk  in  1`: 50 MHz reference clock; the only clock.
- `rst_n  in  1`: synchronous, active-low reset.
- `pll_locked  in  1`: PLL lock flag, asynchronous to `refclk`.
- `pll_rst  out  1`: PLL reset, active high, registered.
- `core_rst_n  out  1`: core reset, active low, registered.
- `ready  out  1`: high in RUN only.
- `fail  out  1`: high in FAIL only.
- `retry_cnt  out  3`: timeouts since the last `rst_n`; saturates at 7.

## Operation
- `pll_locked` passes through a 2-FF synchronizer producing `lock_s`. The synchronizer flops reset to 0.
- A single down/up counter, sized to the largest parameter, is shared by all states. It clears on every state transition.
- States:
  - RESET: `pll_rst`=1. After `RST_PULSE_CYCLES` cycles -> WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1 -> STABLE.
    - Counter reaches `LOCK_TIMEOUT_CYCLES` -> timeout handling (see Configuration).
  - STABLE: counts consecutive `lock_s`=1 cycles.
    - `lock_s`=0 at any cycle -> WAIT_LOCK, with the timeout counter restarted.
    - Count reaches `STABLE_CYCLES` -> RUN.
  - RUN: `core_rst_n`=1, `ready`=1.
    - `lock_s`=0 -> RESET, with `core_rst_n`=0 on the next edge. A lock loss in RUN does not increment `retry_cnt`.
  - FAIL: `pll_rst`=1, `core_rst_n`=0, `fail`=1. Exits only via `rst_n`=0.
- `core_rst_n` is 0 in every state except RUN.
- Reset values (`rst_n`=0): state RESET, counter 0, `pll_rst`=1, `core_rst_n`=0, `ready`=0, `fail`=0, `retry_cnt`=0.
- `rst_n` asserted mid-sequence, in any state, takes effect on the next edge. It restarts the full sequence, including the RESET pulse.

## Timing
- Define edge 0 as the first rising edge sampling `rst_n`=1.
- `pll_rst` is high through edge `RST_PULSE_CYCLES`-1 and low from edge `RST_PULSE_CYCLES`.
- `pll_locked` rising reaches `lock_s` 2 edges later. The state goes to STABLE on the following edge.
- `core_rst_n` and `ready` rise exactly `STABLE_CYCLES` edges after entry into STABLE, provided lock holds throughout.
- `pll_locked` falling in RUN produces `core_rst_n`=0 at most 3 edges later: 2 synchronizer edges plus 1 state edge.
- `lock_s` falling on the same edge that STABLE would complete: the drop wins, and the next state is WAIT_LOCK.
- All outputs are registered; none are combinational from inputs.

## Configuration
- `PLL_RESET_CTRL_RETRY_EN` defined, on a WAIT_LOCK timeout:
  - `retry_cnt` increments.
  - If the new value is ≥ `MAX_RETRIES` -> FAIL, else -> RESET (a new PLL reset pulse).
- `PLL_RESET_CTRL_RETRY_EN` undefined:
  - The timeout counter is not built.
  - WAIT_LOCK waits indefinitely; FAIL is unreachable.
  - `fail` and `retry_cnt` are tied to 0.

## Structure
- Shared package `pll_reset_pkg`:
  - State enum `pll_rst_state_t` (RESET, WAIT_LOCK, STABLE, RUN, FAIL).
  - Counter width function/constant derived from the maximum of the parameters.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with synchronous active-low reset. It is reused by other cores for button/DIP inputs.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=100, `STABLE_CYCLES`=16, `MAX_RETRIES`=2, with retry enabled.
- Normal bring-up:
  - Stimulus: release `rst_n`; raise `pll_locked` at edge 20.
  - Required: `pll_rst` high edges 0–3, low from 4; `core_rst_n`=`ready`=1 at edge 20+2+1+16 = 39.
- Glitch during STABLE:
  - Stimulus: lock at edge 20, drop `pll_locked` for 1 cycle at edge 30, then hold high.
  - Required: `core_rst_n` stays 0 through edge 39 and rises 16 cycles after STABLE re-entry; `retry_cnt`=0.
- Lock loss in RUN:
  - Stimulus: drop `pll_locked` after `ready`.
  - Required: `core_rst_n`=0 within 3 edges; a new 4-cycle `pll_rst` pulse follows; `retry_cnt` unchanged.
- Never locks:
  - Stimulus: hold `pll_locked`=0.
  - Required: two 4-cycle `pll_rst` pulses spaced 104 edges apart; `retry_cnt` goes 1 then 2; then `fail`=1 and `pll_rst`=1 held.
- Mid-sequence reset:
  - Stimulus: pulse `rst_n`=0 for 1 cycle while in STABLE.
  - Required: next edge shows `pll_rst`=1, `core_rst_n`=0, `retry_cnt`=0, followed by a full 4-cycle pulse.
- Retry compiled out:
  - Stimulus: hold `pll_locked`=0 for 1000 edges.
  - Required: single pulse, `pll_rst` stays 0, `fail`=0, `retry_cnt`=0.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_pkg;

  // Sequencer states; the top keeps legacy-style 3-bit constants derived from these.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_rst_state_t;

  // Width of the shared cycle counter. It only ever has to hold (limit - 1)
  // for the largest limit, so $clog2 of the largest value is enough.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-low reset.
// Also used for button and DIP-switch inputs in other cores.
module sync_2ff
  import pll_reset_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; both clear to 0 on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up and reset sequencer on the reference clock.
// Pulses the PLL reset, waits for a synchronized lock that stays high for
// STABLE_CYCLES, then releases the core reset. A lock loss in RUN restarts
// the whole sequence.
// Optional feature macro: PLL_RESET_CTRL_RETRY_EN adds a WAIT_LOCK timeout
// with a retry counter and a terminal FAIL state. Without it WAIT_LOCK waits
// forever and fail/retry_cnt are tied to 0.
// dbg_state exposes the current state encoding for checkers.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] dbg_state
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                STABLE_CYCLES, MAX_RETRIES);

  localparam logic [2:0] S_RESET     = ST_RESET;
  localparam logic [2:0] S_WAIT_LOCK = ST_WAIT_LOCK;
  localparam logic [2:0] S_STABLE    = ST_STABLE;
  localparam logic [2:0] S_RUN       = ST_RUN;
  localparam logic [2:0] S_FAIL      = ST_FAIL;

  // "Counter reaches N" means the N-th counted cycle, i.e. count value N-1.
  localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt;
  logic          cnt_en;
  logic          lock_s;

`ifdef PLL_RESET_CTRL_RETRY_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);
  logic [2:0] retry_nx;
`endif

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state decision; a lock drop always takes priority over completion.
  always_comb begin
    state_nx = state;
    cnt_en   = 1'b0;
`ifdef PLL_RESET_CTRL_RETRY_EN
    retry_nx = retry_cnt;
`endif
    case (state)
      S_RESET: begin
        cnt_en = 1'b1;
        if (cnt == PULSE_LAST) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = S_STABLE;
        end
`ifdef PLL_RESET_CTRL_RETRY_EN
        else begin
          cnt_en = 1'b1;
          if (cnt == TIMEOUT_LAST) begin
            retry_nx = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
            state_nx = (retry_nx >= RETRY_LIMIT) ? S_FAIL : S_RESET;
          end
        end
`endif
      end
      S_STABLE: begin
        cnt_en = 1'b1;
        if (!lock_s)                 state_nx = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) state_nx = S_RESET;
      end
      S_FAIL: begin
        state_nx = S_FAIL;
      end
      default: begin
        state_nx = S_RESET;
      end
    endcase
  end

  // State, shared counter and registered outputs decoded from the next state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state      <= S_RESET;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt_en)       cnt <= cnt + 1'b1;
      pll_rst    <= (state_nx == S_RESET) || (state_nx == S_FAIL);
      core_rst_n <= (state_nx == S_RUN);
      ready      <= (state_nx == S_RUN);
    end
  end

`ifdef PLL_RESET_CTRL_RETRY_EN
  // Retry counter and fail flag; cleared only by rst_n.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      retry_cnt <= 3'd0;
      fail      <= 1'b0;
    end else begin
      retry_cnt <= retry_nx;
      fail      <= (state_nx == S_FAIL);
    end
  end
`else
  assign retry_cnt = 3'd0;
  assign fail      = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: hand-derived checkpoint table for
// the directed scenarios, plus randomized lock waveforms checked against a
// timeline model of the sequencing rules.
module tb_pll_reset_ctrl;

  localparam int P    = 4;
  localparam int T    = 100;
  localparam int S    = 16;
  localparam int MAXR = 2;
`ifdef PLL_RESET_CTRL_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_rst_n, ready, fail;
  logic [2:0] retry_cnt, dbg_state;

  always #10 refclk = ~refclk;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .STABLE_CYCLES       (S),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int e;                       // edges completed since the last rst_n release
  logic [6:0] obs [0:1023];    // {pll_rst, core_rst_n, ready, fail, retry_cnt}

  function automatic logic [6:0] pk(input bit pr, input bit cr, input bit rd,
                                    input bit fl, input int rc);
    logic [31:0] r;
    r = rc;
    return {pr, cr, rd, fl, r[2:0]};
  endfunction

  function automatic logic [6:0] dut_out();
    return {pll_rst, core_rst_n, ready, fail, retry_cnt};
  endfunction

  // ---------------- reference model ----------------
  // Timeline view: which phase we are in, the edge at which it started
  // counting, and the last two lock samples (lock_s lags pll_locked by 2 edges).
  localparam int M_PULSE = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4;
  int m_mode = M_PULSE;
  int m_e = 0;
  int m_t0 = 0;
  int m_retry = 0;
  bit m_hist[$];

  task automatic m_go(input int mode);
    m_mode = mode;
    m_t0   = m_e + 1;
  endtask

  task automatic model_edge(input bit rn, input bit lk);
    bit ls;
    int age;
    if (!rn) begin
      m_mode = M_PULSE; m_e = 0; m_t0 = 0; m_retry = 0;
      m_hist.delete();
      return;
    end
    ls = (m_hist.size() == 2) ? m_hist[0] : 1'b0;
    m_hist.push_back(lk);
    if (m_hist.size() > 2) m_hist.delete(0);
    age = m_e - m_t0;
    case (m_mode)
      M_PULSE:  if (age == P - 1) m_go(M_WAIT);
      M_WAIT: begin
        if (ls) m_go(M_STABLE);
        else if (RETRY && age == T - 1) begin
          m_retry = (m_retry < 7) ? m_retry + 1 : 7;
          m_go((m_retry >= MAXR) ? M_FAIL : M_PULSE);
        end
      end
      M_STABLE: begin
        if (!ls) m_go(M_WAIT);
        else if (age == S - 1) m_go(M_RUN);
      end
      M_RUN:    if (!ls) m_go(M_PULSE);
      default:  ;
    endcase
    m_e++;
  endtask

  function automatic logic [6:0] model_out();
    return pk(m_mode == M_PULSE || m_mode == M_FAIL, m_mode == M_RUN,
              m_mode == M_RUN, m_mode == M_FAIL, RETRY ? m_retry : 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rst,core,rdy,fail,retry}=%b required %b", name, got, exp);
    end
  endtask

  task automatic step(input bit lk, input bit rn);
    pll_locked = lk;
    rst_n      = rn;
    @(posedge refclk);
    model_edge(rn, lk);
    #1;
    e++;
    if (e < 1024) obs[e] = dut_out();
    check($sformatf("model e=%0d", e), dut_out(), model_out());
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    e = 0;
    obs[0] = dut_out();
    check("reset_state", dut_out(), pk(1, 0, 0, 0, 0));
  endtask

  function automatic bit lock_fn(input int s, input int t);
    case (s)
      0, 4: return t >= 20;
      1:    return (t >= 20) && (t != 30);
      2:    return (t >= 20) && (t < 45);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- checkpoint table ----------------
  typedef struct {
    int         scen;
    int         at;
    logic [6:0] exp;
    string      name;
  } chk_t;
  chk_t tbl[$];

  task automatic add(input int s, input int at, input logic [6:0] exp, input string name);
    chk_t c;
    c.scen = s; c.at = at; c.exp = exp; c.name = name;
    tbl.push_back(c);
  endtask

  localparam int SCEN_LEN [0:4] = '{60, 60, 60, 400, 60};

  initial begin
    // Value at edge k == outputs after k edges have completed since release.
    add(0, 3,   pk(1,0,0,0,0), "bringup_pulse_hi_e3");
    add(0, 4,   pk(0,0,0,0,0), "bringup_pulse_lo_e4");
    add(0, 38,  pk(0,0,0,0,0), "bringup_core_lo_e38");
    add(0, 39,  pk(0,1,1,0,0), "bringup_run_e39");
    add(0, 60,  pk(0,1,1,0,0), "bringup_run_hold");
    add(1, 39,  pk(0,0,0,0,0), "glitch_core_lo_e39");
    add(1, 49,  pk(0,0,0,0,0), "glitch_core_lo_e49");
    add(1, 50,  pk(0,1,1,0,0), "glitch_run_e50");
    add(2, 47,  pk(0,1,1,0,0), "loss_still_run");
    add(2, 48,  pk(1,0,0,0,0), "loss_core_lo_3edges");
    add(2, 51,  pk(1,0,0,0,0), "loss_pulse_end");
    add(2, 52,  pk(0,0,0,0,0), "loss_pulse_lo");
    add(3, 103, pk(0,0,0,0,0), "nolock_wait1");
    add(3, 104, RETRY ? pk(1,0,0,0,1) : pk(0,0,0,0,0), "nolock_pulse2_start");
    add(3, 107, RETRY ? pk(1,0,0,0,1) : pk(0,0,0,0,0), "nolock_pulse2_end");
    add(3, 108, RETRY ? pk(0,0,0,0,1) : pk(0,0,0,0,0), "nolock_wait2");
    add(3, 207, RETRY ? pk(0,0,0,0,1) : pk(0,0,0,0,0), "nolock_wait2_end");
    add(3, 208, RETRY ? pk(1,0,0,1,2) : pk(0,0,0,0,0), "nolock_fail");
    add(3, 400, RETRY ? pk(1,0,0,1,2) : pk(0,0,0,0,0), "nolock_fail_hold");
    add(4, 31,  pk(1,0,0,0,0), "midrst_next_edge");
    add(4, 34,  pk(1,0,0,0,0), "midrst_pulse_end");
    add(4, 35,  pk(0,0,0,0,0), "midrst_pulse_lo");
    add(4, 51,  pk(0,0,0,0,0), "midrst_core_lo");
    add(4, 52,  pk(0,1,1,0,0), "midrst_run");

    // Directed scenarios, each from a fresh reset.
    @(posedge refclk); #1;
    for (int s = 0; s < 5; s++) begin
      apply_reset();
      while (e < SCEN_LEN[s]) step(lock_fn(s, e), !(s == 4 && e == 30));
      foreach (tbl[i]) begin
        if (tbl[i].scen == s) check(tbl[i].name, obs[tbl[i].at], tbl[i].exp);
      end
    end

    // Randomized lock waveforms with occasional mid-sequence resets.
    apply_reset();
    for (int r = 0; r < 120; r++) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 40);
      if ($urandom_range(0, 24) == 0) step(lk, 1'b0);
      for (int k = 0; k < len; k++) step(lk, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
